mod_addsub_seq: RTL

- Initiator that drives the shared start/done multi-precision adder (mpadder) to compute modular addition and subtraction, (a ± b) mod M.
- Issues two adder operations back-to-back: a raw add/sub, then a correction by M. The result is selected from the sign/borrow bit.
- Sits between the Montgomery datapath controller and the mpadder instance.
- The adder stays external so that it can be time-shared.

---
 rtl/mod_seq_pkg.sv | 23 ++
 rtl/mod_addsub_seq.sv | 124 ++++++++++++
 2 files changed

// File: rtl/mod_seq_pkg.sv
// Shared definitions for the modular add/sub sequencer: state encoding,
// default operand width and the position of the adder's sign/borrow bit.
package mod_seq_pkg;

  localparam int MODSEQ_DATA_W = 1027;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE1,
    WAIT1,
    ISSUE2,
    WAIT2,
    FIN
  } state_t;

  // The adder result is one bit wider than its operands; the top bit is the sign/borrow
  function automatic int signIdx(input int width);
    return width;
  endfunction

  localparam int MODSEQ_SIGN_IDX = signIdx(MODSEQ_DATA_W);

endpackage

// File: rtl/mod_addsub_seq.sv
// Sequencer computing (a +/- b) mod M with two operations on an external
// start/done adder. Optional macro MODSEQ_EARLY_EXIT_EN skips the correction when a >= b.
module mod_addsub_seq
  import mod_seq_pkg::*;
#(
  parameter int DATA_W = MODSEQ_DATA_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              subtract,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [DATA_W-1:0] in_m,
  output logic [DATA_W-1:0] result,
  output logic              done,
  output logic              busy,
  output logic              add_start,
  output logic              add_subtract,
  output logic [DATA_W-1:0] add_a,
  output logic [DATA_W-1:0] add_b,
  input  logic [DATA_W:0]   add_result,
  input  logic              add_done
);

  localparam int SignBit = signIdx(DATA_W);

  state_t            r_state;
  state_t            w_nextState;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_m;
  logic              r_sub;
  logic [DATA_W:0]   r_r1;
  logic [DATA_W-1:0] r_result;
  logic              w_earlyExit;
  logic              w_loadResult;
  logic [DATA_W-1:0] w_finalResult;

`ifdef MODSEQ_EARLY_EXIT_EN
  // A non-negative difference is already reduced, so the correction can be skipped
  assign w_earlyExit = r_sub & ~add_result[SignBit];
`else
  assign w_earlyExit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start) w_nextState = ISSUE1;
      ISSUE1:  w_nextState = WAIT1;
      WAIT1:   if (add_done) w_nextState = w_earlyExit ? FIN : ISSUE2;
      ISSUE2:  w_nextState = WAIT2;
      WAIT2:   if (add_done) w_nextState = FIN;
      FIN:     w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  assign w_loadResult = add_done &&
                        ((r_state == WAIT2) || ((r_state == WAIT1) && w_earlyExit));

  // Add mode keeps r1 when r1-M went negative; sub mode keeps the second sum as-is
  always_comb begin
    w_finalResult = add_result[DATA_W-1:0];
    if ((r_state == WAIT2) && !r_sub && add_result[SignBit])
      w_finalResult = r_r1[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_a      <= '0;
      r_b      <= '0;
      r_m      <= '0;
      r_sub    <= 1'b0;
      r_r1     <= '0;
      r_result <= '0;
    end else begin
      if ((r_state == IDLE) && start) begin
        r_a   <= in_a;
        r_b   <= in_b;
        r_m   <= in_m;
        r_sub <= subtract;
      end
      if ((r_state == WAIT1) && add_done) r_r1 <= add_result;
      if (w_loadResult) r_result <= w_finalResult;
    end
  end

  always_comb begin
    add_start    = 1'b0;
    add_subtract = 1'b0;
    add_a        = '0;
    add_b        = '0;
    done         = 1'b0;
    busy         = 1'b0;
    case (r_state)
      ISSUE1, WAIT1: begin
        add_start    = (r_state == ISSUE1);
        add_subtract = r_sub;
        add_a        = r_a;
        add_b        = r_b;
        busy         = 1'b1;
      end
      ISSUE2, WAIT2: begin
        add_start    = (r_state == ISSUE2);
        add_subtract = ~r_sub;
        add_a        = r_r1[DATA_W-1:0];
        add_b        = (r_sub && !r_r1[SignBit]) ? '0 : r_m;
        busy         = 1'b1;
      end
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

  assign result = r_result;

endmodule
